// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - BMP format constants, writer state encoding and size helpers
package bmp_pkg;

    localparam int BMP_HEADER_BYTES = 54;
    localparam int BMP_INFO_SIZE    = 40;
    localparam int BMP_BPP          = 24;
    localparam int BMP_PPM          = 2835;

    typedef enum logic [2:0] {
        BMP_IDLE   = 3'd0,
        BMP_HEADER = 3'd1,
        BMP_PIXELS = 3'd2,
        BMP_PAD    = 3'd3,
        BMP_DONE   = 3'd4
    } bmp_state_t;

    // Zero bytes needed to bring a 24-bit row up to a 4-byte boundary.
    function automatic logic [31:0] row_pad(input logic [31:0] width);
        return (32'd4 - ((32'd3 * width) % 32'd4)) % 32'd4;
    endfunction

    function automatic logic [31:0] file_size(input logic [31:0] width, input logic [31:0] height);
        return 32'(BMP_HEADER_BYTES) + (32'd3 * width + row_pad(width)) * height;
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// rtl/bmp_header_rom.sv - combinational 54-byte BMP header lookup for a fixed image geometry
module bmp_header_rom
    import bmp_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 768,
    parameter int IMAGE_HEIGHT = 512
) (
    input  logic [5:0] idx,
    output logic [7:0] data
);

    localparam logic [31:0] FILE_SIZE  = file_size(32'(IMAGE_WIDTH), 32'(IMAGE_HEIGHT));
    localparam logic [31:0] IMG_SIZE   = FILE_SIZE - 32'(BMP_HEADER_BYTES);
    // Negative height marks the image as top-down, so rows stream in arrival order.
    localparam logic [31:0] NEG_HEIGHT = 32'd0 - 32'(IMAGE_HEIGHT);

    function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] sel);
        return 8'(v >> {sel, 3'b000});
    endfunction

    // Every 32-bit field starts at an offset of 2 mod 4, so the low index bits pick the byte.
    logic [1:0] k;
    assign k = idx[1:0] - 2'd2;

    always_comb begin
        data = 8'h00;
        case (idx)
            6'd0:                         data = 8'h42;
            6'd1:                         data = 8'h4D;
            6'd2, 6'd3, 6'd4, 6'd5:       data = le_byte(FILE_SIZE, k);
            6'd10, 6'd11, 6'd12, 6'd13:   data = le_byte(32'(BMP_HEADER_BYTES), k);
            6'd14, 6'd15, 6'd16, 6'd17:   data = le_byte(32'(BMP_INFO_SIZE), k);
            6'd18, 6'd19, 6'd20, 6'd21:   data = le_byte(32'(IMAGE_WIDTH), k);
            6'd22, 6'd23, 6'd24, 6'd25:   data = le_byte(NEG_HEIGHT, k);
            6'd26:                        data = 8'h01;
            6'd28:                        data = 8'(BMP_BPP);
            6'd34, 6'd35, 6'd36, 6'd37:   data = le_byte(IMG_SIZE, k);
            6'd38, 6'd39, 6'd40, 6'd41,
            6'd42, 6'd43, 6'd44, 6'd45:   data = le_byte(32'(BMP_PPM), k);
            default:                      data = 8'h00;
        endcase
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// rtl/bmp_stream_writer.sv - serialises RGB pixel beats into a padded top-down 24-bit BMP byte stream
// Define BMP_STREAM_HEADER_EN to prepend the 54-byte BMP header.
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int IMAGE_WIDTH     = 768,
    parameter int IMAGE_HEIGHT    = 512,
    parameter int PIXELS_PER_BEAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [24*PIXELS_PER_BEAT-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic                         sig_write_done,
    output logic                         busy
);

    localparam int DW         = 24 * PIXELS_PER_BEAT;
    localparam int BEAT_BYTES = 3 * PIXELS_PER_BEAT;
    localparam int PAD        = int'(row_pad(32'(IMAGE_WIDTH)));
    localparam int CW         = $clog2(IMAGE_WIDTH + 1);
    localparam int RW         = $clog2(IMAGE_HEIGHT + 1);
    localparam int NW         = $clog2(BEAT_BYTES + 1);

    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - PIXELS_PER_BEAT);
    localparam logic [CW-1:0] COL_STEP = CW'(PIXELS_PER_BEAT);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
    localparam logic [1:0]    LAST_PAD = 2'(PAD - 1);

    localparam logic [2:0] S_IDLE   = BMP_IDLE;
    localparam logic [2:0] S_PIXELS = BMP_PIXELS;
    localparam logic [2:0] S_PAD    = BMP_PAD;
    localparam logic [2:0] S_DONE   = BMP_DONE;

    logic [2:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    pad_cnt;
    logic [NW-1:0] rem;
    logic [DW-1:0] hold;
    logic          slot_free;

`ifdef BMP_STREAM_HEADER_EN
    localparam logic [2:0] S_HEADER = BMP_HEADER;
    localparam logic [5:0] HDR_LAST = 6'(BMP_HEADER_BYTES - 1);
    logic [5:0] hdr_idx;
    logic [7:0] hdr_byte;

    bmp_header_rom #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_header_rom (
        .idx  (hdr_idx),
        .data (hdr_byte)
    );
`endif

    // The output register can take a new byte when empty or when its byte leaves this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == S_PIXELS) && (rem == '0) && slot_free;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            col            <= '0;
            row            <= '0;
            pad_cnt        <= '0;
            rem            <= '0;
            hold           <= '0;
            out_valid      <= 1'b0;
            out_byte       <= 8'h00;
            out_last       <= 1'b0;
            sig_write_done <= 1'b0;
`ifdef BMP_STREAM_HEADER_EN
            hdr_idx        <= '0;
`endif
        end else begin
            sig_write_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        col     <= '0;
                        row     <= '0;
                        pad_cnt <= '0;
                        rem     <= '0;
`ifdef BMP_STREAM_HEADER_EN
                        out_valid <= 1'b1;
                        out_byte  <= 8'h42;
                        hdr_idx   <= 6'd1;
                        state     <= S_HEADER;
`else
                        state     <= S_PIXELS;
`endif
                    end
                end
`ifdef BMP_STREAM_HEADER_EN
                S_HEADER: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_byte  <= hdr_byte;
                        if (hdr_idx == HDR_LAST) state <= S_PIXELS;
                        else hdr_idx <= hdr_idx + 6'd1;
                    end
                end
`endif
                S_PIXELS: begin
                    if (slot_free) begin
                        if (rem != '0) begin
                            out_valid <= 1'b1;
                            out_byte  <= hold[7:0];
                            hold      <= hold >> 8;
                            rem       <= rem - NW'(1);
                            // Row bookkeeping happens as the last byte of a beat is loaded.
                            if (rem == NW'(1)) begin
                                if (col == LAST_COL) begin
                                    col <= '0;
                                    if (PAD != 0) begin
                                        state <= S_PAD;
                                    end else if (row == LAST_ROW) begin
                                        state    <= S_DONE;
                                        out_last <= 1'b1;
                                    end else begin
                                        row <= row + RW'(1);
                                    end
                                end else begin
                                    col <= col + COL_STEP;
                                end
                            end
                        end else if (in_valid) begin
                            out_valid <= 1'b1;
                            out_byte  <= in_data[7:0];
                            hold      <= in_data >> 8;
                            rem       <= NW'(BEAT_BYTES - 1);
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_byte  <= 8'h00;
                        if (pad_cnt == LAST_PAD) begin
                            pad_cnt <= '0;
                            if (row == LAST_ROW) begin
                                state    <= S_DONE;
                                out_last <= 1'b1;
                            end else begin
                                row   <= row + RW'(1);
                                state <= S_PIXELS;
                            end
                        end else begin
                            pad_cnt <= pad_cnt + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    // Holds the final byte until the sink takes it, then returns to IDLE.
                    if (out_ready) begin
                        out_valid      <= 1'b0;
                        out_last       <= 1'b0;
                        sig_write_done <= 1'b1;
                        row            <= '0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bmp_stream_writer.md
# bmp_stream_writer

Synthesizable successor to the simulation-only BMP dump. It accepts processed RGB pixels, PIXELS_PER_BEAT at a time, through a valid/ready handshake. It serializes them into a byte-exact 24-bit BMP byte stream on a valid/ready byte port, including the optional 54-byte header and mandatory 4-byte row padding. It sits at the end of the threshold pipeline and feeds a UART/DMA/file sink.

## Interface
- IMAGE_WIDTH, 768: pixels per row; must be a multiple of PIXELS_PER_BEAT.
- IMAGE_HEIGHT, 512: rows per frame.
- PIXELS_PER_BEAT, 2: pixels per input beat (2 = even/odd pair); range 1..8.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous and active-high.
- start  input  1  one-cycle frame-start request; honoured only in IDLE.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  24*PIXELS_PER_BEAT  pixel p at bits [24p+23:24p], packed as R[23:16], G[15:8], B[7:0]; pixel 0 is the leftmost.
- out_valid  output  1  out_byte valid.
- out_ready  input  1  sink accepts byte.
- out_byte  output  8  stream byte.
- out_last  output  1  marks the final byte of the frame.
- sig_write_done  output  1  one-cycle pulse after the final byte is accepted.
- busy  output  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: start → HEADER, or → PIXELS when the header is compiled out.
  - HEADER: 54 bytes, then → PIXELS.
  - PIXELS: serializes each beat.
  - PAD: row padding; → PIXELS, or → DONE after the last row.
  - DONE: one cycle, pulses sig_write_done, → IDLE.
- Header bytes are little-endian:
  - "BM"
  - file size = 54 + ROW_BYTES*IMAGE_HEIGHT
  - 0 (32-bit)
  - offset 54
  - 40
  - IMAGE_WIDTH
  - −IMAGE_HEIGHT in 32-bit two's complement, giving a top-down image so no frame buffer is needed
  - planes 1 (16-bit)
  - bpp 24 (16-bit)
  - compression 0
  - image size = ROW_BYTES*IMAGE_HEIGHT
  - 2835, 2835
  - 0, 0
- ROW_BYTES = 3*IMAGE_WIDTH + PAD; PAD = (4 − (3*IMAGE_WIDTH mod 4)) mod 4. All arithmetic is done at elaboration time on 32-bit constants.
- PIXELS state:
  - A beat is captured into a 3*PIXELS_PER_BEAT-byte holding register.
  - Bytes are emitted in per-pixel order B, G, R, from pixel 0 upward.
  - in_ready = (state==PIXELS) && holding register empty, or its last byte is being accepted this cycle. This allows back-to-back beats with no bubble.
- Column counter runs 0..IMAGE_WIDTH−1 in steps of PIXELS_PER_BEAT; row counter runs 0..IMAGE_HEIGHT−1.
- At end of row: PAD zero bytes if PAD>0; otherwise go directly to the next row, or to DONE.
- out_last = 1 on the final data or pad byte of the last row only.
- start outside IDLE is ignored. in_valid outside PIXELS is ignored (in_ready=0).

## Timing
- Reset values:
  - state IDLE
  - in_ready 0
  - out_valid 0
  - out_byte 0x00
  - out_last 0
  - sig_write_done 0
  - busy 0
  - all counters 0
- start at cycle T → out_valid=1 with byte 'B' (0x42) at T+1. With the header compiled out, in_ready=1 at T+1.
- out_byte, out_last and out_valid are registered and held stable while out_valid && !out_ready.
- Beat accepted at T (in_valid && in_ready) → its first byte is on out_byte at T+1.
- Throughput: 1 byte/cycle under continuous out_ready.
- Final byte accepted at T → sig_write_done=1 and busy=0 at T+1; a new start is honoured at T+1.
- reset asserted mid-frame → immediate return to reset values. The partial frame is discarded; no done pulse is issued.

## Configuration
- BMP_STREAM_HEADER_EN defined: the 54-byte header is emitted before the pixel data, as above.
- BMP_STREAM_HEADER_EN undefined: the HEADER state and header ROM are removed; the stream is raw padded top-down BGR rows only. File-size constants are still computed but unused.

## Structure
- Package bmp_pkg holds:
  - BMP_HEADER_BYTES=54, BMP_INFO_SIZE=40, BMP_BPP=24, BMP_PPM=2835
  - the state enum typedef
  - the functions row_pad(width) and file_size(width,height)
- One sub-module, bmp_header_rom: a combinational index → byte lookup, parametrised by width and height.

## Test plan
- IMAGE_WIDTH=6, IMAGE_HEIGHT=2, PIXELS_PER_BEAT=2, header on, out_ready=1:
  - bytes 0..5 = 42 4D 5E 00 00 00 (file size 94)
  - bytes 22..25 = FE FF FF FF
  - 94 bytes total; out_last only on byte 93; sig_write_done one cycle later.
- Same configuration, pixel {R=0x11,G=0x22,B=0x33} in every slot:
  - each row is 33 22 11 ×6 followed by 00 00 pad.
- IMAGE_WIDTH=4, PIXELS_PER_BEAT=4 (PAD=0):
  - row is 12 bytes with no pad
  - image size field = 12*IMAGE_HEIGHT.
- Random out_ready (50%) and random in_valid gaps:
  - byte stream identical to the no-stall run
  - out_byte never changes while out_valid && !out_ready.
- reset asserted mid-row 1, then start:
  - outputs at reset values
  - the new frame restarts from byte 0x42 with counters at 0.
- start pulsed during PIXELS:
  - ignored, and the frame length is unchanged.
- Header compiled out:
  - the first accepted beat's B byte is the first output byte
  - total = 40 bytes for the 6×2 case.
